// File: rtl/register_scoreboard_pkg.sv
// Shared types for the decode-stage register scoreboard.
// Register 0 is hardwired, so decode helpers never produce a strobe for it.
package register_scoreboard_pkg;

    localparam int REG_ADDRESS_WIDTH = 5;
    localparam int NUM_REGS          = 1 << REG_ADDRESS_WIDTH;

    typedef logic [REG_ADDRESS_WIDTH-1:0] RegAddress;

    function automatic logic [NUM_REGS-1:0] oneHot(input logic en, input RegAddress addr);
        oneHot = '0;
        if (en && (addr != '0)) begin
            oneHot[addr] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/register_scoreboard_if.sv
// Issue/writeback/kill bundle between the decode stage and the register scoreboard.
// The pipeline side is the master; the scoreboard answers with stall, busy_mask and error.
interface register_scoreboard_if;
    import register_scoreboard_pkg::*;

    logic                issue_valid;
    RegAddress           issue_rs1;
    RegAddress           issue_rs2;
    logic                issue_use_rs1;
    logic                issue_use_rs2;
    RegAddress           issue_rd;
    logic                issue_wr_rd;
    logic                wb_valid;
    RegAddress           wb_rd;
    logic                kill_valid;
    RegAddress           kill_rd;
    logic                stall;
    logic [NUM_REGS-1:0] busy_mask;
    logic                error;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
        output issue_rd, issue_wr_rd, wb_valid, wb_rd, kill_valid, kill_rd,
        input  stall, busy_mask, error
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
        input  issue_rd, issue_wr_rd, wb_valid, wb_rd, kill_valid, kill_rd,
        output stall, busy_mask, error
    );

endinterface

// File: rtl/register_scoreboard_counter.sv
// Per-register in-flight writer counter; all same-edge events fold into one net delta.
// Out-of-range results clamp and raise a one-cycle underflow/overflow flag.
module scoreboard_counter #(
    parameter int MAX_INFLIGHT = 3,
    parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc_i,
    input  logic          dec_wb_i,
    input  logic          dec_kill_i,
    output logic [CW-1:0] cnt_o,
    output logic          underflow_o,
    output logic          overflow_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    int            netCount;

    always_comb begin
        netCount    = int'(cnt_q) + int'(inc_i) - int'(dec_wb_i) - int'(dec_kill_i);
        underflow_o = (netCount < 0);
        overflow_o  = (netCount > MAX_INFLIGHT);
        cnt_d       = CW'(netCount);
        if (underflow_o) begin
            cnt_d = '0;
        end else if (overflow_o) begin
            cnt_d = CW'(MAX_INFLIGHT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/register_scoreboard.sv
// Decode-stage RAW hazard tracker in front of the write-then-read register file.
// A writeback on the same edge as a read is forwarded by the rf, so it does not stall.
module register_scoreboard
    import register_scoreboard_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic             clk,
    input  logic             reset,
    register_scoreboard_if.slave sb
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [CW-1:0]       cnt [NUM_REGS];
    logic [NUM_REGS-1:0] wbHot;
    logic [NUM_REGS-1:0] killHot;
    logic [NUM_REGS-1:1] incHot;
    logic [NUM_REGS-1:1] underflow;
    logic [NUM_REGS-1:1] overflow;
    logic                stallRs1;
    logic                stallRs2;
    logic                stallRd;
    logic                accept;
    logic                error_q;
    logic                error_d;

    assign wbHot   = oneHot(sb.wb_valid, sb.wb_rd);
    assign killHot = oneHot(sb.kill_valid, sb.kill_rd);
    assign cnt[0]  = '0;

    // A source is pending if anything remains after this cycle's writeback lands.
    always_comb begin
        stallRs1 = sb.issue_use_rs1 &&
                   (({1'b0, cnt[sb.issue_rs1]} - {{CW{1'b0}}, wbHot[sb.issue_rs1]}) != '0);
        stallRs2 = sb.issue_use_rs2 &&
                   (({1'b0, cnt[sb.issue_rs2]} - {{CW{1'b0}}, wbHot[sb.issue_rs2]}) != '0);
        stallRd  = sb.issue_wr_rd && (sb.issue_rd != '0) &&
                   (cnt[sb.issue_rd] == CW'(MAX_INFLIGHT)) &&
                   !wbHot[sb.issue_rd] && !killHot[sb.issue_rd];
        sb.stall = sb.issue_valid && (stallRs1 || stallRs2 || stallRd);
    end

    assign accept = sb.issue_valid && !sb.stall;

    always_comb begin
        incHot = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            incHot[r] = accept && sb.issue_wr_rd && (sb.issue_rd == RegAddress'(r));
        end
    end

    for (genvar r = 1; r < NUM_REGS; r++) begin : gCounter
        scoreboard_counter #(
            .MAX_INFLIGHT (MAX_INFLIGHT),
            .CW           (CW)
        ) uCounter (
            .clk         (clk),
            .reset       (reset),
            .inc_i       (incHot[r]),
            .dec_wb_i    (wbHot[r]),
            .dec_kill_i  (killHot[r]),
            .cnt_o       (cnt[r]),
            .underflow_o (underflow[r]),
            .overflow_o  (overflow[r])
        );
    end

    always_comb begin
        sb.busy_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            sb.busy_mask[r] = (cnt[r] != '0);
        end
    end

    assign error_d = error_q || (|underflow) || (|overflow);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign sb.error = error_q;

endmodule
